// File: rtl/csr_router_pkg.sv
// Purpose: shared opcodes, FSM state type and address-range helper for csr_router.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csr_router_pkg;

   localparam logic [3:0] WRITE_CMD_DEF = 4'h1;
   localparam logic [3:0] READ_CMD_DEF  = 4'h2;
   localparam logic [3:0] BURST_CMD_DEF = 4'h3;

   typedef enum logic [1:0] {IDLE, WDATA, BCOUNT, BDATA} state_t;

   // True when addr falls inside the channel window [base, base+num_ch).
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] num_ch);
      return (addr >= base) && (addr < base + num_ch);
   endfunction

endpackage

// File: rtl/csr_router_edge_sync.sv
// Purpose: 2-flop synchroniser plus previous-value flop; flags each rising edge of async_in.
// Latency: async_in sampled at edge k raises evt for the cycle k+1 -> k+2.
// Backpressure: none; every rising edge yields exactly one evt cycle.
// Ports: clk, rst_n (async active-low), async_in (level from another domain), evt (one-cycle pulse).
module edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic evt
);

   logic sync1;
   logic sync2;
   logic prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= async_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign evt = sync2 & ~prev;

endmodule

// File: rtl/csr_router.sv
// Purpose: decodes SPI command/data words into channel writes, bursts and read responses.
// Latency: in_valid sampled at edge k -> strobes/response/state/err_cnt updated at edge k+2.
// Backpressure: rsp_valid held until rsp_ready; a new READ while pending overwrites and counts an error.
// Ports: clk, rst_n, in_data/in_valid (SPI word), ch_data/ch_valid (shadow + strobes),
//        rsp_data/rsp_valid/rsp_ready (read response), err_cnt (saturating), busy (state != IDLE).
module csr_router
   import csr_router_pkg::*;
#(
   parameter int                NUM_CH    = 4,
   parameter int                CMD_W     = 4,
   parameter int                ADDR_W    = 12,
   parameter int                DATA_W    = CMD_W + ADDR_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter logic [CMD_W-1:0]  WRITE_CMD = WRITE_CMD_DEF,
   parameter logic [CMD_W-1:0]  READ_CMD  = READ_CMD_DEF,
   parameter logic [CMD_W-1:0]  BURST_CMD = BURST_CMD_DEF,
   parameter int                ERR_W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_valid,
   output logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [NUM_CH-1:0]        ch_valid,
   output logic [DATA_W-1:0]        rsp_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ERR_W-1:0]         err_cnt,
   output logic                     busy
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   state_t                          state;
   logic [IDX_W-1:0]                idx;
   logic [DATA_W-1:0]               remaining;
   logic [NUM_CH-1:0][DATA_W-1:0]   shadow;

   logic                            word_evt;
   logic [CMD_W-1:0]                opcode;
   logic [ADDR_W-1:0]               addr;
   logic                            addr_ok;
   logic [IDX_W-1:0]                addr_idx;
   logic                            err_evt;

   edge_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (in_valid),
      .evt      (word_evt)
   );

   assign opcode   = in_data[DATA_W-1 -: CMD_W];
   assign addr     = in_data[ADDR_W-1:0];
   assign addr_ok  = addr_in_range(32'(addr), 32'(BASE_ADDR), 32'(NUM_CH));
   assign addr_idx = IDX_W'(addr - BASE_ADDR);
   assign ch_data  = shadow;

   // At most one error source per event, so the counter only ever steps by one.
   always_comb begin
      err_evt = 1'b0;
      if (word_evt) begin
         case (state)
            IDLE: begin
               if (!addr_ok ||
                   !((opcode == WRITE_CMD) || (opcode == READ_CMD) || (opcode == BURST_CMD)))
                  err_evt = 1'b1;
               else if ((opcode == READ_CMD) && rsp_valid && !rsp_ready)
                  err_evt = 1'b1;
            end
            BCOUNT:  err_evt = (in_data == '0);
            default: err_evt = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         idx       <= '0;
         remaining <= '0;
         shadow    <= '0;
         ch_valid  <= '0;
         rsp_data  <= '0;
         rsp_valid <= 1'b0;
         err_cnt   <= '0;
      end else begin
         ch_valid <= '0;

         // Handshake clears first; a READ in the same cycle re-asserts below.
         if (rsp_valid && rsp_ready)
            rsp_valid <= 1'b0;

         if (err_evt && (err_cnt != '1))
            err_cnt <= err_cnt + 1'b1;

         if (word_evt) begin
            case (state)
               IDLE: begin
                  if (addr_ok) begin
                     if (opcode == WRITE_CMD) begin
                        idx   <= addr_idx;
                        state <= WDATA;
                        busy  <= 1'b1;
                     end else if (opcode == BURST_CMD) begin
                        idx   <= addr_idx;
                        state <= BCOUNT;
                        busy  <= 1'b1;
                     end else if (opcode == READ_CMD) begin
                        rsp_data  <= shadow[addr_idx];
                        rsp_valid <= 1'b1;
                     end
                  end
               end
               WDATA: begin
                  shadow[idx]   <= in_data;
                  ch_valid[idx] <= 1'b1;
                  state         <= IDLE;
                  busy          <= 1'b0;
               end
               BCOUNT: begin
                  if (in_data == '0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     remaining <= in_data;
                     state     <= BDATA;
                  end
               end
               BDATA: begin
                  shadow[idx]   <= in_data;
                  ch_valid[idx] <= 1'b1;
                  idx           <= (idx == IDX_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
                  remaining     <= remaining - 1'b1;
                  if (remaining == DATA_W'(1)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_csr_router.sv
// Purpose: directed self-checking bench for csr_router (default parameters, NUM_CH = 4).
// Latency: each SPI word occupies 6 clk cycles (4 high, 2 low).
// Backpressure: rsp_ready driven explicitly by the bench.
module tb_csr_router;

   logic        clk;
   logic        rst_n;
   logic [15:0] in_data;
   logic        in_valid;
   logic [63:0] ch_data;
   logic [3:0]  ch_valid;
   logic [15:0] rsp_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  err_cnt;
   logic        busy;

   int          n_assert;
   int          n_fail;
   logic [3:0]  strobe_seen;
   int          strobe_cycles;

   csr_router dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .ch_data   (ch_data),
      .ch_valid  (ch_valid),
      .rsp_data  (rsp_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .err_cnt   (err_cnt),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents one word (4 cycles high, 2 low) and records every strobe seen meanwhile.
   task automatic send_word(input logic [15:0] w);
      strobe_seen   = '0;
      strobe_cycles = 0;
      in_data       = w;
      in_valid      = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         strobe_seen = strobe_seen | ch_valid;
         if (ch_valid != '0) strobe_cycles++;
         if (i == 3) in_valid = 1'b0;
      end
   endtask

   task automatic pulse_ready();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      n_assert  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_ch_data",   ch_data,   64'h0);
      chk("rst_ch_valid",  ch_valid,  4'h0);
      chk("rst_rsp_data",  rsp_data,  16'h0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_err_cnt",   err_cnt,   8'h0);
      chk("rst_busy",      busy,      1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single write to channel 2
      send_word(16'h1002);
      chk("wr_cmd_busy",   busy,          1'b1);
      chk("wr_cmd_nostb",  strobe_cycles, 0);
      send_word(16'hBEEF);
      chk("wr_strobe",     strobe_seen,   4'b0100);
      chk("wr_strobe_len", strobe_cycles, 1);
      chk("wr_ch2",        ch_data[32 +: 16], 16'hBEEF);
      chk("wr_busy_done",  busy,          1'b0);

      // Burst of 3 starting at channel 3, wrapping to 0 and 1
      send_word(16'h3003);
      send_word(16'h0003);
      chk("bst_busy",      busy,          1'b1);
      send_word(16'h0011);
      chk("bst_stb0",      strobe_seen,   4'b1000);
      chk("bst_stb0_len",  strobe_cycles, 1);
      send_word(16'h0022);
      chk("bst_stb1",      strobe_seen,   4'b0001);
      send_word(16'h0033);
      chk("bst_stb2",      strobe_seen,   4'b0010);
      chk("bst_stb2_len",  strobe_cycles, 1);
      chk("bst_ch3",       ch_data[48 +: 16], 16'h0011);
      chk("bst_ch0",       ch_data[0 +: 16],  16'h0022);
      chk("bst_ch1",       ch_data[16 +: 16], 16'h0033);
      chk("bst_busy_done", busy,          1'b0);

      // Read-back with held response
      send_word(16'h1000);
      send_word(16'hA5A5);
      send_word(16'h2000);
      repeat (10) @(negedge clk);
      chk("rd_valid_held", rsp_valid,     1'b1);
      chk("rd_data",       rsp_data,      16'hA5A5);
      chk("rd_no_err",     err_cnt,       8'h00);
      pulse_ready();
      chk("rd_cleared",    rsp_valid,     1'b0);

      // Protocol errors
      send_word(16'h7000);
      chk("bad_op_err",    err_cnt,       8'h01);
      chk("bad_op_nostb",  strobe_cycles, 0);
      chk("bad_op_busy",   busy,          1'b0);
      send_word(16'h1010);
      chk("bad_addr_err",  err_cnt,       8'h02);
      chk("bad_addr_busy", busy,          1'b0);
      send_word(16'h1002);
      send_word(16'h0000);
      send_word(16'h3000);
      send_word(16'h0000);
      chk("bst0_err",      err_cnt,       8'h03);
      chk("bst0_busy",     busy,          1'b0);
      chk("bst0_nostb",    strobe_cycles, 0);
      chk("wr_zero_ch2",   ch_data[32 +: 16], 16'h0000);

      // Second READ while a response is pending
      send_word(16'h1002);
      send_word(16'hBEEF);
      send_word(16'h2002);
      chk("rd1_data",      rsp_data,      16'hBEEF);
      chk("rd1_err",       err_cnt,       8'h03);
      send_word(16'h2000);
      chk("rd2_data",      rsp_data,      16'hA5A5);
      chk("rd2_valid",     rsp_valid,     1'b1);
      chk("rd2_err",       err_cnt,       8'h04);
      pulse_ready();
      chk("rd2_cleared",   rsp_valid,     1'b0);

      // Reset in the middle of a burst
      send_word(16'h3001);
      send_word(16'h0003);
      send_word(16'h0055);
      chk("mid_ch1",       ch_data[16 +: 16], 16'h0055);
      chk("mid_busy",      busy,          1'b1);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_rst_data",  ch_data,       64'h0);
      chk("mid_rst_busy",  busy,          1'b0);
      chk("mid_rst_err",   err_cnt,       8'h00);
      chk("mid_rst_rsp",   {rsp_valid, rsp_data}, 17'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      send_word(16'h1002);
      chk("post_rst_nostb", strobe_cycles, 0);
      chk("post_rst_busy",  busy,          1'b1);
      send_word(16'h7777);
      chk("post_rst_stb",   strobe_seen,   4'b0100);
      chk("post_rst_ch2",   ch_data[32 +: 16], 16'h7777);
      chk("post_rst_ch1",   ch_data[16 +: 16], 16'h0000);

      // Error counter saturation
      for (int i = 0; i < 254; i++) send_word(16'h7000);
      chk("sat_254",       err_cnt,       8'hFE);
      for (int i = 0; i < 46; i++) send_word(16'h7000);
      chk("sat_300",       err_cnt,       8'hFF);
      chk("sat_busy",      busy,          1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/csr_router.md
# csr_router

Parametrised command decoder between the SPI word link and the accelerator's control/status registers. Each 16-bit SPI word is either a command (opcode + register address) or a data word. The block routes writes to NUM_CH register channels, adds burst writes, keeps a per-channel shadow copy for read-back, and returns read data over a held valid/ready handshake. It replaces the fixed three-channel decoder and counts protocol errors.

## Interface
Parameters:
- NUM_CH, 4, number of register channels (2..16)
- CMD_W, 4, opcode width
- ADDR_W, 12, address width; DATA_W = CMD_W + ADDR_W
- DATA_W, 16, SPI word and channel data width
- BASE_ADDR, 12'h000, address of channel 0; channel i is at BASE_ADDR+i
- WRITE_CMD, 4'h1 / READ_CMD, 4'h2 / BURST_CMD, 4'h3, opcodes
- ERR_W, 8, error counter width

Ports:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  DATA_W  SPI word; stable while in_valid is high
- in_valid  in  1  level from SPI side, asynchronous to clk; one word per low→high transition
- ch_data  out  NUM_CH×DATA_W  per-channel written value (shadow register)
- ch_valid  out  NUM_CH  one-cycle write strobe per channel
- rsp_data  out  DATA_W  read response
- rsp_valid  out  1  response pending
- rsp_ready  in  1  SPI side accepts response
- err_cnt  out  ERR_W  saturating protocol-error count
- busy  out  1  FSM not in IDLE

## Operation
- in_valid passes through a 2-flop synchroniser; word event = sync2 & ~prev. in_data is sampled in the event cycle.
- Command decode in IDLE: opcode = in_data[DATA_W-1 -: CMD_W], addr = in_data[ADDR_W-1:0].
- An address is valid iff BASE_ADDR ≤ addr < BASE_ADDR+NUM_CH; idx = addr − BASE_ADDR.
- IDLE:
  - WRITE_CMD + valid addr → WDATA, latch idx.
  - BURST_CMD + valid addr → BCOUNT, latch idx.
  - READ_CMD + valid addr → rsp_data ← ch_data[idx], rsp_valid ← 1; stay IDLE.
  - Any other opcode, or an invalid addr → err_cnt+1; stay IDLE.
- WDATA: next word is data, not parsed as a command. ch_data[idx] ← word, ch_valid[idx] pulses → IDLE.
- BCOUNT: word is count n.
  - n = 0 → err_cnt+1 → IDLE.
  - Otherwise remaining ← n → BDATA.
- BDATA: each word writes channel idx and pulses its strobe. Then idx ← (idx == NUM_CH−1) ? 0 : idx+1 and remaining−1. At remaining = 1 → IDLE.
- Response handshake: rsp_valid stays high until a cycle with rsp_ready = 1, then clears.
  - A READ that arrives while rsp_valid = 1 and no handshake in that cycle overwrites rsp_data and increments err_cnt.
  - A handshake and a new READ in the same cycle: new data loads, rsp_valid stays 1, no error.
- err_cnt saturates at all-ones.
- Read-back of a channel written in the same event is impossible; events are exclusive.

## Timing
- Reset values:
  - ch_data: all 0
  - ch_valid: 0
  - rsp_data: 0
  - rsp_valid: 0
  - err_cnt: 0
  - busy: 0
  - FSM: IDLE
  - synchroniser and prev: 0
- Reset mid-burst or mid-write abandons the transaction, with no strobe.
- Latency: in_valid sampled high at edge k gives an event in cycle k+1→k+2. Registered results (ch_valid, rsp_valid, state, err_cnt) are visible after edge k+2.
- ch_valid is high for exactly one clk cycle per data word.
- Minimum word spacing is 4 clk cycles of in_valid high plus 2 low; faster toggling is outside the contract.
- busy is registered and equals state ≠ IDLE.

## Structure
- Package csr_router_pkg holds:
  - opcode localparams (WRITE/READ/BURST defaults)
  - state enum {IDLE, WDATA, BCOUNT, BDATA}
  - a function checking address validity.
- Sub-module edge_sync holds the 2-flop synchroniser, prev flop and rising-event output, with reset to 0. It is reused by other SPI-facing blocks.
- Top contains the FSM, the shadow registers (written only from the FSM), the response register and the error counter.

## Test plan
- WRITE at addr 0x002 (0x1002), then data 0xBEEF → ch_data[2] = 0xBEEF, ch_valid = 4'b0100 for one cycle, busy back to 0.
- BURST at addr 0x003 (0x3003), count 3, data 0x11/0x22/0x33:
  - writes ch3 = 0x11, ch0 = 0x22, ch1 = 0x33 (wrap)
  - three single-cycle strobes.
- READ at addr 0x000 (0x2000) after writing 0xA5A5 to ch0, rsp_ready held 0 for 10 cycles → rsp_valid stays 1 with 0xA5A5; rsp_ready pulse clears it.
- Errors:
  - Opcode 0x7, or address 0x010 with NUM_CH = 4 → err_cnt increments, no strobe, state stays IDLE.
  - BURST with count 0 → err_cnt+1.
  - 300 bad commands with ERR_W = 8 → err_cnt = 0xFF.
- Mid-operation cases:
  - rst_n low during BDATA after 1 of 3 words → all outputs at reset values, next word decoded as a command.
  - Second READ while response pending → rsp_data replaced, err_cnt+1.
